// File: rtl/packet_header_tx_pkg.sv
// ============================================================================
// Module   : packet_header_tx_pkg
// Brief    : Shared widths, state encoding and header word indices for the
//            transmit-side packet framer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package packet_header_tx_pkg;

   localparam int WORD_WIDTH = 16;
   localparam int LEN_WIDTH  = 8;

   typedef enum logic [2:0] {
      ST_PARK  = 3'd0,
      ST_ARMED = 3'd1,
      ST_HDR   = 3'd2,
      ST_PAY   = 3'd3,
      ST_TRL   = 3'd4,
      ST_FIN   = 3'd5
   } state_t;

   localparam logic [1:0] HDR_DEST = 2'd0;
   localparam logic [1:0] HDR_SRC  = 2'd1;
   localparam logic [1:0] HDR_SEQ  = 2'd2;
   localparam logic [1:0] HDR_LEN  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/packet_header_tx_if.sv
// ============================================================================
// Module   : packet_header_tx_if
// Brief    : Control handshake, payload input and word stream output of the
//            packet framer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface packet_header_tx_if;
   import packet_header_tx_pkg::*;

   logic                  en;
   logic                  start;
   logic [WORD_WIDTH-1:0] MY_NODE_ID;
   logic [WORD_WIDTH-1:0] destinationID;
   logic [LEN_WIDTH-1:0]  payload_len;
   logic [WORD_WIDTH-1:0] payload_data;
   logic                  payload_valid;
   logic                  payload_ready;
   logic [WORD_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  tx_last;
   logic                  done;
   logic                  err;

   modport master (
      output en, start, MY_NODE_ID, destinationID, payload_len,
             payload_data, payload_valid, tx_ready,
      input  payload_ready, tx_data, tx_valid, tx_last, done, err
   );

   modport slave (
      input  en, start, MY_NODE_ID, destinationID, payload_len,
             payload_data, payload_valid, tx_ready,
      output payload_ready, tx_data, tx_valid, tx_last, done, err
   );

endinterface

`default_nettype wire

// File: rtl/packet_header_tx_xor_checksum_acc.sv
// ============================================================================
// Module   : packet_header_tx_xor_checksum_acc
// Brief    : Running XOR of every word loaded into the output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_header_tx_xor_checksum_acc
   import packet_header_tx_pkg::*;
(
   input  logic                  clock,
   input  logic                  nrst,
   input  logic                  clear_i,
   input  logic                  load_i,
   input  logic [WORD_WIDTH-1:0] word_i,
   output logic [WORD_WIDTH-1:0] acc_o
);

   logic [WORD_WIDTH-1:0] acc_q;
   logic [WORD_WIDTH-1:0] acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clear_i) begin
         acc_d = '0;
      end else if (load_i) begin
         acc_d = acc_q ^ word_i;
      end
   end

   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/packet_header_tx.sv
// ============================================================================
// Module   : packet_header_tx
// Brief    : Transmit framer: header (dest, src, seq, len), payload words and
//            an XOR checksum trailer on a registered valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_header_tx
   import packet_header_tx_pkg::*;
(
   input  logic               clock,
   input  logic               nrst,
   packet_header_tx_if.slave  bus
);

   state_t                state_q, state_d;
   logic [WORD_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  tx_last_q, tx_last_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [WORD_WIDTH-1:0] seq_q, seq_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [1:0]            idx_q, idx_d;
   logic [WORD_WIDTH-1:0] dest_q, dest_d;
   logic [WORD_WIDTH-1:0] src_q, src_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;

   logic                  w_drain;
   logic                  w_payload_ready;
   logic                  w_ck_clear;
   logic                  w_ck_load;
   logic [WORD_WIDTH-1:0] w_ck_acc;
   logic [1:0]            w_next_idx;
   logic [WORD_WIDTH-1:0] w_hdr_word;

   // Output register can take a new word when empty or being consumed now.
   assign w_drain = !tx_valid_q || bus.tx_ready;

   always_comb begin
      w_next_idx = idx_q + 2'd1;
      case (w_next_idx)
         HDR_SRC: w_hdr_word = src_q;
         HDR_SEQ: w_hdr_word = seq_q;
         HDR_LEN: w_hdr_word = {{(WORD_WIDTH-LEN_WIDTH){1'b0}}, len_q};
         default: w_hdr_word = dest_q;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      tx_data_d       = tx_data_q;
      tx_valid_d      = tx_valid_q;
      tx_last_d       = tx_last_q;
      done_d          = done_q;
      err_d           = err_q;
      seq_d           = seq_q;
      cnt_d           = cnt_q;
      idx_d           = idx_q;
      dest_d          = dest_q;
      src_d           = src_q;
      len_d           = len_q;
      w_ck_clear      = 1'b0;
      w_ck_load       = 1'b0;
      w_payload_ready = 1'b0;

      case (state_q)
         ST_PARK: begin
            if (bus.en) begin
               state_d    = ST_ARMED;
               done_d     = 1'b0;
               err_d      = 1'b0;
               w_ck_clear = 1'b1;
            end
         end

         ST_ARMED: begin
            if (bus.start) begin
               dest_d = bus.destinationID;
               src_d  = bus.MY_NODE_ID;
               len_d  = bus.payload_len;
               cnt_d  = bus.payload_len;
               if (bus.destinationID == bus.MY_NODE_ID) begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d    = ST_HDR;
                  tx_data_d  = bus.destinationID;
                  tx_valid_d = 1'b1;
                  idx_d      = HDR_DEST;
                  w_ck_load  = 1'b1;
               end
            end
         end

         ST_HDR: begin
            if (tx_valid_q && bus.tx_ready) begin
               if (idx_q == HDR_LEN) begin
                  if (len_q == '0) begin
                     state_d   = ST_TRL;
                     tx_data_d = w_ck_acc;
                     tx_last_d = 1'b1;
                  end else begin
                     state_d    = ST_PAY;
                     tx_valid_d = 1'b0;
                  end
               end else begin
                  idx_d     = w_next_idx;
                  tx_data_d = w_hdr_word;
                  w_ck_load = 1'b1;
               end
            end
         end

         ST_PAY: begin
            if (cnt_q != '0) begin
               w_payload_ready = w_drain;
               if (bus.payload_valid && w_drain) begin
                  tx_data_d  = bus.payload_data;
                  tx_valid_d = 1'b1;
                  cnt_d      = cnt_q - LEN_WIDTH'(1);
                  w_ck_load  = 1'b1;
               end else if (bus.tx_ready) begin
                  tx_valid_d = 1'b0;
               end
            end else if (w_drain) begin
               // Last payload word is already folded into the accumulator.
               state_d    = ST_TRL;
               tx_data_d  = w_ck_acc;
               tx_valid_d = 1'b1;
               tx_last_d  = 1'b1;
            end
         end

         ST_TRL: begin
            if (tx_valid_q && bus.tx_ready) begin
               state_d    = ST_FIN;
               tx_valid_d = 1'b0;
               tx_last_d  = 1'b0;
               done_d     = 1'b1;
            end
         end

         ST_FIN: begin
            if (!err_q) begin
               seq_d = seq_q + WORD_WIDTH'(1);
            end
            state_d = ST_PARK;
         end

         default: begin
            state_d = ST_PARK;
         end
      endcase
   end

   always_ff @(posedge clock or negedge nrst) begin
      if (!nrst) begin
         state_q    <= ST_PARK;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         seq_q      <= '0;
         cnt_q      <= '0;
         idx_q      <= HDR_DEST;
         dest_q     <= '0;
         src_q      <= '0;
         len_q      <= '0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         tx_last_q  <= tx_last_d;
         done_q     <= done_d;
         err_q      <= err_d;
         seq_q      <= seq_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         dest_q     <= dest_d;
         src_q      <= src_d;
         len_q      <= len_d;
      end
   end

   packet_header_tx_xor_checksum_acc u_csum (
      .clock   (clock),
      .nrst    (nrst),
      .clear_i (w_ck_clear),
      .load_i  (w_ck_load),
      .word_i  (tx_data_d),
      .acc_o   (w_ck_acc)
   );

   assign bus.tx_data       = tx_data_q;
   assign bus.tx_valid      = tx_valid_q;
   assign bus.tx_last       = tx_last_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;
   assign bus.payload_ready = w_payload_ready;

endmodule

`default_nettype wire

// File: tb/tb_packet_header_tx.sv
// ============================================================================
// Module   : tb_packet_header_tx
// Brief    : Randomised bench with a queue-based packet model for the framer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_packet_header_tx;
   import packet_header_tx_pkg::*;

   logic clock = 1'b0;
   logic nrst  = 1'b0;
   always #5 clock = ~clock;

   packet_header_tx_if bus();

   packet_header_tx dut (
      .clock (clock),
      .nrst  (nrst),
      .bus   (bus)
   );

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_q[$];
   logic [15:0] pay_src[$];
   logic [15:0] seen_q[$];
   logic [15:0] fixed_pay[$];
   logic [15:0] m_seq = 16'h0000;
   int          tmode = 0;
   int          pmode = 0;
   bit          chk_en = 1'b0;
   int          cur_len = 0;
   int          pay_acc = 0;
   bit          exp_done_next = 1'b0;
   bit          hold = 1'b0;
   logic [15:0] hold_data = 16'h0;
   logic        hold_last = 1'b0;

   logic [15:0] lit1 [7] = '{16'h0005, 16'h0001, 16'h0000, 16'h0002,
                              16'hAAAA, 16'h5555, 16'hFFF9};
   logic [15:0] lit2 [5] = '{16'h0002, 16'h0001, 16'h0000, 16'h0000, 16'h0003};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Stream driver and per-cycle compare against the expected word queue.
   initial begin
      logic [15:0] w;
      bus.tx_ready      = 1'b0;
      bus.payload_valid = 1'b0;
      bus.payload_data  = 16'h0;
      forever begin
         @(negedge clock);
         if (chk_en && hold) begin
            check("stall_valid", 32'(bus.tx_valid), 32'd1);
            check("stall_data", 32'(bus.tx_data), 32'(hold_data));
            check("stall_last", 32'(bus.tx_last), 32'(hold_last));
         end
         case (tmode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = ~bus.tx_ready;
            default: bus.tx_ready = 1'($urandom_range(0, 1));
         endcase
         if (pay_src.size() > 0 && (pmode == 0 || $urandom_range(0, 2) != 0)) begin
            bus.payload_valid = 1'b1;
            bus.payload_data  = pay_src[0];
         end else begin
            bus.payload_valid = 1'b0;
            bus.payload_data  = 16'($urandom);
         end
         #4;
         if (chk_en) begin
            if (exp_done_next) begin
               check("done_after_trailer", 32'(bus.done), 32'd1);
               check("err_normal", 32'(bus.err), 32'd0);
               exp_done_next = 1'b0;
            end
            if (bus.payload_ready) begin
               check("pready_within_len", 32'(pay_acc < cur_len), 32'd1);
            end
            if (bus.payload_valid && bus.payload_ready) begin
               void'(pay_src.pop_front());
               pay_acc++;
            end
            if (bus.tx_valid && bus.tx_ready) begin
               seen_q.push_back(bus.tx_data);
               check("done_low_in_packet", 32'(bus.done), 32'd0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %h expected no word", bus.tx_data);
               end else begin
                  w = exp_q.pop_front();
                  check("word", 32'(bus.tx_data), 32'(w));
                  check("tx_last", 32'(bus.tx_last), 32'(exp_q.size() == 0));
                  if (exp_q.size() == 0) exp_done_next = 1'b1;
               end
            end
            hold      = bus.tx_valid && !bus.tx_ready;
            hold_data = bus.tx_data;
            hold_last = bus.tx_last;
         end else begin
            hold = 1'b0;
         end
      end
   end

   task automatic build_model(input logic [15:0] id, input logic [15:0] dest, input int len);
      logic [15:0] csum;
      logic [15:0] w;
      seen_q.delete();
      pay_acc = 0;
      cur_len = len;
      if (dest != id) begin
         csum = dest ^ id ^ m_seq ^ 16'(len);
         exp_q.push_back(dest);
         exp_q.push_back(id);
         exp_q.push_back(m_seq);
         exp_q.push_back(16'(len));
         for (int i = 0; i < len; i++) begin
            if (fixed_pay.size() > 0) w = fixed_pay.pop_front();
            else                      w = 16'($urandom);
            pay_src.push_back(w);
            exp_q.push_back(w);
            csum = csum ^ w;
         end
         exp_q.push_back(csum);
      end
   endtask

   task automatic arm_and_start(input logic [15:0] id, input logic [15:0] dest, input int len);
      @(negedge clock);
      bus.MY_NODE_ID    = id;
      bus.destinationID = dest;
      bus.payload_len   = 8'(len);
      bus.en            = 1'b1;
      @(negedge clock);
      bus.en = 1'b0;
      check("done_cleared", 32'(bus.done), 32'd0);
      check("err_cleared", 32'(bus.err), 32'd0);
      build_model(id, dest, len);
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic send_pkt(input logic [15:0] id, input logic [15:0] dest, input int len,
                           input int tm, input int pm, input bit rnd_ctl);
      int cyc;
      tmode = tm;
      pmode = pm;
      arm_and_start(id, dest, len);
      if (dest == id) begin
         check("self_done_next", 32'(bus.done), 32'd1);
         check("self_err", 32'(bus.err), 32'd1);
      end
      cyc = 0;
      while (!bus.done && cyc < 3000) begin
         if (rnd_ctl) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.en    = 1'($urandom_range(0, 1));
         end
         @(negedge clock);
         cyc++;
      end
      bus.start = 1'b0;
      bus.en    = 1'b0;
      check("done_timeout", 32'(cyc < 3000), 32'd1);
      check("err_flag", 32'(bus.err), 32'(dest == id));
      repeat (2) @(negedge clock);
      check("words_left", 32'(exp_q.size()), 32'd0);
      check("payload_left", 32'(pay_src.size()), 32'd0);
      exp_q.delete();
      pay_src.delete();
      if (dest != id) m_seq = m_seq + 16'd1;
      @(negedge clock);
      check("done_held", 32'(bus.done), 32'd1);
   endtask

   task automatic do_reset();
      chk_en    = 1'b0;
      nrst      = 1'b0;
      bus.en    = 1'b0;
      bus.start = 1'b0;
      repeat (2) @(negedge clock);
      nrst = 1'b1;
      m_seq = 16'h0000;
      exp_q.delete();
      pay_src.delete();
      exp_done_next = 1'b0;
      @(negedge clock);
      chk_en = 1'b1;
   endtask

   task automatic check_seq_field(input string name, input logic [15:0] exp);
      if (seen_q.size() > 2) check(name, 32'(seen_q[2]), 32'(exp));
      else                   check(name, 32'(seen_q.size()), 32'd3);
   endtask

   initial begin
      int cyc;
      logic [15:0] id;
      logic [15:0] dest;
      bus.en            = 1'b0;
      bus.start         = 1'b0;
      bus.MY_NODE_ID    = 16'h0;
      bus.destinationID = 16'h0;
      bus.payload_len   = 8'h0;
      nrst = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("rst_tx_last", 32'(bus.tx_last), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_pready", 32'(bus.payload_ready), 32'd0);
      nrst = 1'b1;
      @(negedge clock);
      chk_en = 1'b1;

      // Case 1: nominal packet at full throughput
      fixed_pay.push_back(16'hAAAA);
      fixed_pay.push_back(16'h5555);
      send_pkt(16'h0001, 16'h0005, 2, 0, 0, 1'b0);
      check("case1_count", 32'(seen_q.size()), 32'd7);
      for (int i = 0; i < 7 && i < seen_q.size(); i++) check("case1_word", 32'(seen_q[i]), 32'(lit1[i]));

      // Case 2: empty payload
      do_reset();
      send_pkt(16'h0001, 16'h0002, 0, 0, 0, 1'b0);
      check("case2_count", 32'(seen_q.size()), 32'd5);
      for (int i = 0; i < 5 && i < seen_q.size(); i++) check("case2_word", 32'(seen_q[i]), 32'(lit2[i]));

      // Case 3: self-addressed packet is refused and does not consume seq 1
      send_pkt(16'h0007, 16'h0007, 3, 0, 0, 1'b0);
      check("self_no_words", 32'(seen_q.size()), 32'd0);
      send_pkt(16'h0007, 16'h0009, 1, 0, 0, 1'b0);
      check_seq_field("case3_seq", 16'h0001);

      // Case 4: stalls and payload gaps, same content as case 1
      do_reset();
      fixed_pay.push_back(16'hAAAA);
      fixed_pay.push_back(16'h5555);
      send_pkt(16'h0001, 16'h0005, 2, 1, 1, 1'b0);
      check("case4_count", 32'(seen_q.size()), 32'd7);
      for (int i = 0; i < 7 && i < seen_q.size(); i++) check("case4_word", 32'(seen_q[i]), 32'(lit1[i]));

      // Randomised packets, including refused ones and a maximum-length one
      for (int k = 0; k < 20; k++) begin
         id   = 16'($urandom);
         dest = ($urandom_range(0, 4) == 0) ? id : 16'($urandom);
         send_pkt(id, dest, (k == 7) ? 255 : int'($urandom_range(0, 12)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 1'b1);
      end

      // Case 5: sequence number wrap
      @(negedge clock);
      force dut.seq_q = 16'hFFFF;
      @(negedge clock);
      release dut.seq_q;
      m_seq = 16'hFFFF;
      send_pkt(16'h0010, 16'h0020, 1, 2, 1, 1'b0);
      check_seq_field("case5_seq_ffff", 16'hFFFF);
      send_pkt(16'h0010, 16'h0020, 2, 0, 0, 1'b0);
      check_seq_field("case5_seq_wrap", 16'h0000);

      // Case 6: reset in the middle of the payload
      send_pkt(16'h0011, 16'h0022, 1, 0, 0, 1'b0);
      tmode = 0;
      pmode = 0;
      arm_and_start(16'h0001, 16'h0003, 4);
      cyc = 0;
      while (pay_acc < 1 && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
      check("case6_reach_pay", 32'(cyc < 100), 32'd1);
      #2;
      chk_en = 1'b0;
      nrst   = 1'b0;
      #1;
      check("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("abort_tx_data", 32'(bus.tx_data), 32'd0);
      check("abort_tx_last", 32'(bus.tx_last), 32'd0);
      check("abort_pready", 32'(bus.payload_ready), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      exp_q.delete();
      pay_src.delete();
      exp_done_next = 1'b0;
      m_seq = 16'h0000;
      @(negedge clock);
      nrst = 1'b1;
      bus.start = 1'b1;
      repeat (3) @(negedge clock);
      bus.start = 1'b0;
      check("start_ignored_valid", 32'(bus.tx_valid), 32'd0);
      check("start_ignored_done", 32'(bus.done), 32'd0);
      chk_en = 1'b1;
      send_pkt(16'h0001, 16'h0003, 2, 2, 1, 1'b0);
      check_seq_field("case6_seq_restart", 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end

endmodule

`default_nettype wire
